// File: rtl/decoder_n_pipe.sv
// SEL_W-to-2**SEL_W one-hot/thermometer decoder with registered output and a 2-entry skid buffer.
// Optional macro DECODER_N_PIPE_STATS_EN adds a 16-bit input-transfer counter port ACC_CNT.
module decoder_n_pipe #(
    parameter int                      SEL_W   = 3,
    parameter logic [(2**SEL_W)-1:0]   RST_VAL = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [SEL_W-1:0]        DATA_IN,
    input  logic                    IN_MODE,
    input  logic                    IN_EN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [(2**SEL_W)-1:0]   DATA_OUT
`ifdef DECODER_N_PIPE_STATS_EN
    ,
    output logic [15:0]             ACC_CNT
`endif
);

    localparam int OUT_W = 2**SEL_W;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_main;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid;
    logic             r_in_ready;

    logic             w_accept;
    logic [OUT_W-1:0] w_decoded;
    logic             w_out_valid_nxt;
    logic [OUT_W-1:0] w_main_nxt;
    logic             w_skid_valid_nxt;
    logic [OUT_W-1:0] w_skid_nxt;

    assign w_accept  = IN_VALID & r_in_ready;
    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign DATA_OUT  = r_main;

    // Decode once at accept time; the stored word never looks at the inputs again.
    always_comb begin
        w_decoded = '0;
        if (IN_EN) begin
            for (int i = 0; i < OUT_W; i++) begin
                w_decoded[i] = IN_MODE ? (i <= int'(DATA_IN)) : (i == int'(DATA_IN));
            end
        end
    end

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_main_nxt       = r_main;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_nxt       = r_skid;
        if (r_skid_valid) begin
            // IN_READY is low here, so only the skid-to-main drain can happen.
            if (OUT_READY) begin
                w_main_nxt       = r_skid;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (!r_out_valid || OUT_READY) begin
            w_out_valid_nxt = w_accept;
            if (w_accept) begin
                w_main_nxt = w_decoded;
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_decoded;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_valid  <= 1'b0;
            r_main       <= RST_VAL;
            r_skid_valid <= 1'b0;
            r_skid       <= RST_VAL;
            r_in_ready   <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_main       <= w_main_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

`ifdef DECODER_N_PIPE_STATS_EN
    logic [15:0] r_acc_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc_cnt <= 16'd0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 16'd1;
        end
    end

    assign ACC_CNT = r_acc_cnt;
`endif

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Scoreboard bench for decoder_n_pipe (SEL_W=3): directed sweeps, backpressure, async reset and a random phase.
// Drivers push expected words at accept time; an independent monitor pops and compares on output transfers.
module tb_decoder_n_pipe;

    localparam logic [7:0] TB_RST_VAL = 8'hA5;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [2:0] DATA_IN;
    logic       IN_MODE;
    logic       IN_EN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] DATA_OUT;
`ifdef DECODER_N_PIPE_STATS_EN
    logic [15:0] ACC_CNT;
`endif

    decoder_n_pipe #(.SEL_W(3), .RST_VAL(TB_RST_VAL)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .DATA_IN   (DATA_IN),
        .IN_MODE   (IN_MODE),
        .IN_EN     (IN_EN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DATA_OUT  (DATA_OUT)
`ifdef DECODER_N_PIPE_STATS_EN
        ,
        .ACC_CNT   (ACC_CNT)
`endif
    );

    int         nChecks = 0;
    int         nBad = 0;
    int         cycleCnt = 0;
    int         popCount = 0;
    int         nAccepts = 0;
    int         lastAcceptCycle = 0;
    int         popCycles[$];
    logic [7:0] sb[$];
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic       randPhase = 1'b0;

    logic [7:0] sweepExp[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [2:0] thermK[3]   = '{3'd0, 3'd3, 3'd7};
    logic [7:0] thermExp[3] = '{8'h01, 8'h0F, 8'hFF};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic logic [7:0] refDecode(input logic [2:0] k, input logic mode, input logic en);
        logic [15:0] w;
        if (!en)
            w = 16'h0000;
        else if (mode)
            w = (16'd1 << (int'(k) + 1)) - 16'd1;
        else
            w = 16'd1 << int'(k);
        return w[7:0];
    endfunction

    // Called at posedge+1; holds inputs over one edge and records the expected word when it will be accepted.
    task automatic applyStimulus(input logic v, input logic [2:0] k, input logic mode, input logic en,
                                 input logic rdy, input logic [7:0] exp, output logic acc);
        IN_VALID  = v;
        DATA_IN   = k;
        IN_MODE   = mode;
        IN_EN     = en;
        OUT_READY = rdy;
        @(negedge CLK);
        acc = v && IN_READY;
        if (acc) begin
            sb.push_back(exp);
            nAccepts++;
            lastAcceptCycle = cycleCnt;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic sendWord(input logic [2:0] k, input logic mode, input logic en,
                            input logic rdy, input logic [7:0] exp);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            applyStimulus(1'b1, k, mode, en, rdy, exp, acc);
        end
        if (!acc) begin
            nChecks++;
            nBad++;
            $display("[TB] FAIL accept_timeout: k=%0d not accepted within 20 cycles", k);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int t = 0; t < n; t++) begin
            applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, rdy, 8'h00, acc);
        end
    endtask

    // Output monitor: compares every transfer against the scoreboard and checks stall stability.
    always @(negedge CLK) begin
        if (RST) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_hold_data", DATA_OUT, prevData);
                checkOutput("stall_hold_valid", OUT_VALID, 1);
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    nChecks++;
                    nBad++;
                    $display("[TB] FAIL unexpected_word: got %0h with empty scoreboard", DATA_OUT);
                end else begin
                    checkOutput("data_out", DATA_OUT, sb.pop_front());
                    popCount++;
                    popCycles.push_back(cycleCnt);
                end
            end
            prevStall = OUT_VALID && !OUT_READY;
            prevData  = DATA_OUT;
        end
    end

    // After every edge the scoreboard length equals the words held inside the DUT.
    always @(posedge CLK) begin
        #2;
        if (randPhase && !RST) checkOutput("occupancy_le2", sb.size() <= 2, 1);
    end

    initial begin
        int c0;
        int p0;
        int a0;
        logic acc;

        RST = 1'b1; IN_VALID = 1'b0; DATA_IN = '0; IN_MODE = 1'b0; IN_EN = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_out_valid", OUT_VALID, 0);
        checkOutput("reset_in_ready", IN_READY, 0);
        checkOutput("reset_data_out", DATA_OUT, TB_RST_VAL);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(2, 1'b1);
        checkOutput("in_ready_after_reset", IN_READY, 1);

        $display("[TB] one-hot sweep");
        c0 = cycleCnt;
        p0 = popCount;
        sendWord(3'd0, 1'b0, 1'b1, 1'b1, sweepExp[0]);
        a0 = lastAcceptCycle;
        for (int i = 1; i < 8; i++) sendWord(3'(i), 1'b0, 1'b1, 1'b1, sweepExp[i]);
        checkOutput("sweep_cycles", cycleCnt - c0, 8);
        idle(2, 1'b1);
        checkOutput("sweep_pops", popCount - p0, 8);
        if (popCount - p0 == 8) begin
            checkOutput("sweep_latency", popCycles[p0], a0 + 1);
            checkOutput("sweep_no_bubble", popCycles[p0 + 7] - popCycles[p0], 7);
        end

        $display("[TB] thermometer and enable");
        for (int i = 0; i < 3; i++) sendWord(thermK[i], 1'b1, 1'b1, 1'b1, thermExp[i]);
        for (int i = 0; i < 3; i++) sendWord(thermK[i], 1'b1, 1'b0, 1'b1, 8'h00);
        idle(3, 1'b1);
        checkOutput("therm_drained", sb.size(), 0);

        $display("[TB] backpressure");
        sendWord(3'd2, 1'b0, 1'b1, 1'b0, 8'h04);
        sendWord(3'd5, 1'b0, 1'b1, 1'b0, 8'h20);
        checkOutput("bp_in_ready_low", IN_READY, 0);
        checkOutput("bp_out_valid", OUT_VALID, 1);
        checkOutput("bp_data_held", DATA_OUT, 8'h04);
        idle(2, 1'b0);
        checkOutput("bp_still_held", DATA_OUT, 8'h04);
        p0 = popCount;
        idle(2, 1'b1);
        checkOutput("bp_pops", popCount - p0, 2);
        checkOutput("bp_in_ready_back", IN_READY, 1);
        checkOutput("bp_drained", sb.size(), 0);

        $display("[TB] async reset with both entries full");
        sendWord(3'd1, 1'b0, 1'b1, 1'b0, 8'h02);
        sendWord(3'd4, 1'b0, 1'b1, 1'b0, 8'h10);
        #3;
        RST = 1'b1;
        sb.delete();
        nAccepts = 0;
        #1;
        checkOutput("async_rst_out_valid", OUT_VALID, 0);
        checkOutput("async_rst_data", DATA_OUT, TB_RST_VAL);
        checkOutput("async_rst_in_ready", IN_READY, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(1, 1'b1);
        p0 = popCount;
        sendWord(3'd6, 1'b0, 1'b1, 1'b1, 8'h40);
        idle(3, 1'b1);
        checkOutput("post_rst_pops", popCount - p0, 1);
        checkOutput("post_rst_drained", sb.size(), 0);

        $display("[TB] random traffic");
        randPhase = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic       v;
            logic [2:0] k;
            logic       m;
            logic       e;
            logic       r;
            v = 1'($urandom_range(0, 1));
            k = 3'($urandom_range(0, 7));
            m = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 1));
            applyStimulus(v, k, m, e, r, refDecode(k, m, e), acc);
        end
        randPhase = 1'b0;
        idle(4, 1'b1);
        checkOutput("random_drained", sb.size(), 0);

`ifdef DECODER_N_PIPE_STATS_EN
        checkOutput("acc_cnt", ACC_CNT, 16'(nAccepts));
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
